mem_copy_engine: RTL

- Bus initiator that drives the single-port data memory interface (addr, data_in, enable, wr, createdump in; data_out back) to copy a block of 32-bit words from a source region to a destination region.
- Sits beside the CPU datapath on the data-memory side and is muxed onto the memory port by the top level while busy=1.
- Each word costs one read cycle followed by one write cycle; a single DONE cycle follows the last write.

---
 rtl/mem_copy_engine_if.sv | 33 +++
 rtl/mem_copy_engine.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mem_copy_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_copy_engine_if
// Description : Single-port data memory bus between the copy engine and memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_copy_engine_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        mem_enable;
    logic        mem_wr;
    logic        mem_createdump;

    modport master (
        output mem_addr,
        output mem_data_in,
        output mem_enable,
        output mem_wr,
        output mem_createdump,
        input  mem_data_out
    );

    modport slave (
        input  mem_addr,
        input  mem_data_in,
        input  mem_enable,
        input  mem_wr,
        input  mem_createdump,
        output mem_data_out
    );
endinterface
`default_nettype wire

// File: rtl/mem_copy_engine.sv
`default_nettype none
// ============================================================================
// Module      : mem_copy_engine
// Description : Word-by-word memory block copier (one read + one write per word).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_copy_engine #(
    parameter int unsigned ADDR_STEP    = 4,
    parameter int          LEN_W        = 16,
    parameter bit          DUMP_ON_DONE = 1'b0
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             start,
    input  wire logic             abort,
    input  wire logic [31:0]      src_addr,
    input  wire logic [31:0]      dst_addr,
    input  wire logic [LEN_W-1:0] len,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [LEN_W-1:0]      words_copied,
    mem_copy_engine_if.master     mem
);

    localparam logic [31:0]      c_step = 32'(ADDR_STEP);
    localparam logic [LEN_W-1:0] c_one  = LEN_W'(1);
    localparam logic             c_dump = DUMP_ON_DONE;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_ABORT = 3'd4
    } state_t;

    state_t           r_state;
    logic [31:0]      r_src_ptr;
    logic [31:0]      r_dst_ptr;
    logic [LEN_W-1:0] r_remaining;
    logic [LEN_W-1:0] r_words_copied;
    logic [31:0]      r_mem_addr;
    logic [31:0]      r_mem_data_in;
    logic             r_mem_enable;
    logic             r_mem_wr;
    logic             r_mem_createdump;
    logic             r_busy;
    logic             r_done;
    logic             r_aborted;

    logic [31:0]      w_src_next;
    logic [31:0]      w_dst_next;

    assign w_src_next = r_src_ptr + c_step;
    assign w_dst_next = r_dst_ptr + c_step;

    // Every output is registered: each transition loads the values the next state drives.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_src_ptr        <= '0;
            r_dst_ptr        <= '0;
            r_remaining      <= '0;
            r_words_copied   <= '0;
            r_mem_addr       <= '0;
            r_mem_data_in    <= '0;
            r_mem_enable     <= 1'b0;
            r_mem_wr         <= 1'b0;
            r_mem_createdump <= 1'b0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_aborted        <= 1'b0;
        end else begin
            r_done           <= 1'b0;
            r_aborted        <= 1'b0;
            r_mem_createdump <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_src_ptr      <= src_addr;
                        r_dst_ptr      <= dst_addr;
                        r_remaining    <= len;
                        r_words_copied <= '0;
                        r_busy         <= 1'b1;
                        if (len == '0) begin
                            r_state          <= S_DONE;
                            r_done           <= 1'b1;
                            r_mem_createdump <= c_dump;
                        end else begin
                            r_state      <= S_READ;
                            r_mem_addr   <= src_addr;
                            r_mem_enable <= 1'b1;
                            r_mem_wr     <= 1'b0;
                        end
                    end
                end
                S_READ: begin
                    if (abort) begin
                        // Word just read is dropped; nothing reaches the destination.
                        r_state      <= S_ABORT;
                        r_aborted    <= 1'b1;
                        r_mem_enable <= 1'b0;
                        r_mem_addr   <= '0;
                    end else begin
                        r_state       <= S_WRITE;
                        r_mem_addr    <= r_dst_ptr;
                        r_mem_data_in <= mem.mem_data_out;
                        r_mem_wr      <= 1'b1;
                    end
                end
                S_WRITE: begin
                    r_src_ptr      <= w_src_next;
                    r_dst_ptr      <= w_dst_next;
                    r_remaining    <= r_remaining - c_one;
                    r_words_copied <= r_words_copied + c_one;
                    r_mem_data_in  <= '0;
                    r_mem_wr       <= 1'b0;
                    if (abort) begin
                        r_state      <= S_ABORT;
                        r_aborted    <= 1'b1;
                        r_mem_enable <= 1'b0;
                        r_mem_addr   <= '0;
                    end else if (r_remaining == c_one) begin
                        r_state          <= S_DONE;
                        r_done           <= 1'b1;
                        r_mem_createdump <= c_dump;
                        r_mem_enable     <= 1'b0;
                        r_mem_addr       <= '0;
                    end else begin
                        r_state    <= S_READ;
                        r_mem_addr <= w_src_next;
                    end
                end
                S_DONE, S_ABORT: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_busy       <= 1'b0;
                    r_mem_enable <= 1'b0;
                    r_mem_wr     <= 1'b0;
                    r_mem_addr   <= '0;
                end
            endcase
        end
    end

    assign mem.mem_addr       = r_mem_addr;
    assign mem.mem_data_in    = r_mem_data_in;
    assign mem.mem_enable     = r_mem_enable;
    assign mem.mem_wr         = r_mem_wr;
    assign mem.mem_createdump = r_mem_createdump;
    assign busy               = r_busy;
    assign done               = r_done;
    assign aborted            = r_aborted;
    assign words_copied       = r_words_copied;

endmodule
`default_nettype wire
